// File: rtl/scan_peak_detector.sv
// Scan peak detector: after start and a trig, tracks the signed extreme of scan_len valid samples and its index.
// Optional macro SCAN_PEAK_MIN_EN adds a find_min input that selects minimum tracking instead of maximum.

`ifndef OPO_PACKAGE_DEFINED
`define OPO_PACKAGE_DEFINED
package opo_package;
   parameter int word_width = 16;
endpackage
`endif

module scan_peak_detector #(
   parameter int idx_width = 16
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic                                        abort,
   input  logic                                        trig,
   input  logic        [idx_width-1:0]                 scan_len,
`ifdef SCAN_PEAK_MIN_EN
   input  logic                                        find_min,
`endif
   input  logic signed [opo_package::word_width-1:0]   sample_in,
   input  logic                                        sample_in_valid,
   output logic                                        busy,
   output logic                                        done,
   output logic signed [opo_package::word_width-1:0]   peak_value,
   output logic        [idx_width-1:0]                 peak_index,
   output logic                                        peak_valid
);

   localparam int W = opo_package::word_width;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SCAN  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [idx_width-1:0]   len_q, len_d;
   logic [idx_width-1:0]   cnt_q, cnt_d;
   logic signed [W-1:0]    best_q, best_d;
   logic [idx_width-1:0]   best_idx_q, best_idx_d;
   logic                   first_q, first_d;
   logic signed [W-1:0]    peak_value_q, peak_value_d;
   logic [idx_width-1:0]   peak_index_q, peak_index_d;
   logic                   peak_valid_q, peak_valid_d;
   logic                   done_q, done_d;
   logic                   find_min_q, find_min_d;
   logic                   find_min_in;

`ifdef SCAN_PEAK_MIN_EN
   assign find_min_in = find_min;
`else
   assign find_min_in = 1'b0;
`endif

   logic                   start_accept;
   logic                   sample_take;
   logic                   last_sample;
   logic                   better;
   logic signed [W-1:0]    cand_value;
   logic [idx_width-1:0]   cand_idx;

   assign start_accept = (state_q == IDLE) && start && (scan_len != '0);
   assign sample_take  = (state_q == SCAN) && !abort && sample_in_valid;
   assign last_sample  = sample_take && (cnt_q == len_q - idx_width'(1));

   // Strict comparisons keep the earliest index on ties.
   assign better     = first_q || (find_min_q ? (sample_in < best_q) : (sample_in > best_q));
   assign cand_value = better ? sample_in : best_q;
   assign cand_idx   = better ? cnt_q : best_idx_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_accept) state_d = ARMED;
         end
         ARMED: begin
            if (abort)     state_d = IDLE;
            else if (trig) state_d = SCAN;
         end
         SCAN: begin
            if (abort || last_sample) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ARMED) || (state_q == SCAN);
   end

   always_comb begin
      len_d        = len_q;
      cnt_d        = cnt_q;
      best_d       = best_q;
      best_idx_d   = best_idx_q;
      first_d      = first_q;
      peak_value_d = peak_value_q;
      peak_index_d = peak_index_q;
      peak_valid_d = peak_valid_q;
      done_d       = 1'b0;
      find_min_d   = find_min_q;
      if (start_accept) begin
         len_d        = scan_len;
         find_min_d   = find_min_in;
         peak_valid_d = 1'b0;
      end
      if ((state_q == ARMED) && !abort && trig) begin
         cnt_d   = '0;
         first_d = 1'b1;
      end
      if (sample_take) begin
         best_d     = cand_value;
         best_idx_d = cand_idx;
         first_d    = 1'b0;
         cnt_d      = cnt_q + idx_width'(1);
      end
      // The final sample is folded in directly so the result appears one edge after it.
      if (last_sample) begin
         peak_value_d = cand_value;
         peak_index_d = cand_idx;
         peak_valid_d = 1'b1;
         done_d       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q        <= '0;
         cnt_q        <= '0;
         best_q       <= '0;
         best_idx_q   <= '0;
         first_q      <= 1'b0;
         peak_value_q <= '0;
         peak_index_q <= '0;
         peak_valid_q <= 1'b0;
         done_q       <= 1'b0;
         find_min_q   <= 1'b0;
      end else begin
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         best_q       <= best_d;
         best_idx_q   <= best_idx_d;
         first_q      <= first_d;
         peak_value_q <= peak_value_d;
         peak_index_q <= peak_index_d;
         peak_valid_q <= peak_valid_d;
         done_q       <= done_d;
         find_min_q   <= find_min_d;
      end
   end

   assign done       = done_q;
   assign peak_value = peak_value_q;
   assign peak_index = peak_index_q;
   assign peak_valid = peak_valid_q;

endmodule
